// File: rtl/instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Fetch-side prefetch queue for the pipelined RISC-V core. It issues
// sequential instruction-memory requests over a grant/response handshake,
// buffers returned instructions together with their PCs, and presents the
// head entry to the fetch stage. An execute-stage redirect flushes the queue,
// restarts fetching at the new target and discards all responses still owed
// to the old stream.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a kept response arriving while the queue is empty is shown
//   on instrValid/instrF/PCF in the same cycle (combinational path from
//   imemRvalid/imemRdata). When undefined, all outputs come from registers.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   redirect          taken branch/jump from execute
//   redirectPC        new fetch target (bits [1:0] ignored)
//   take              fetch stage consumes the head entry this cycle
//   instrValid        head entry valid
//   instrF            head instruction, NOP (32'h13) when not valid
//   PCF               PC of head entry, next expected PC when empty
//   PCPlus4F          PCF + 4
//   imemReq/imemAddr  request valid / word-aligned request address
//   imemGnt           request accepted this cycle
//   imemRvalid/Rdata  in-order response valid / instruction
// ---------------------------------------------------------------------------
module instruction_prefetch_buffer #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    input  logic        take,
    output logic        instrValid,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam int               OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

    // Control state
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OUT_W-1:0] r_inflight;
    logic [OUT_W-1:0] r_drop_cnt;

    // Queue storage (data only, never reset)
    logic [31:0]      r_instr_mem [DEPTH];
    logic [31:0]      r_pc_mem    [DEPTH];

    logic             w_fifo_empty;
    logic             w_keep_rsp;
    logic [CNT_W:0]   w_occupancy;
    logic             w_req;
    logic             w_grant;
    logic             w_bypass;
    logic             w_head_valid;
    logic             w_pop;
    logic             w_fifo_pop;
    logic             w_push;
    logic [31:0]      w_redirect_pc;

    assign w_redirect_pc = redirectPC & 32'hFFFF_FFFC;
    assign w_fifo_empty  = (r_count == '0);
    assign w_keep_rsp    = imemRvalid && (r_drop_cnt == '0);

    // Every accepted request reserves a queue slot, so the queue can never
    // overflow regardless of how responses bunch up.
    assign w_occupancy   = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
    assign w_req         = !rst && !redirect && (r_inflight < MAX_OUT_C)
                           && (w_occupancy < DEPTH_C);
    assign w_grant       = w_req && imemGnt;

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass      = w_fifo_empty && w_keep_rsp;
`else
    assign w_bypass      = 1'b0;
`endif

    assign w_head_valid  = !w_fifo_empty || w_bypass;
    assign w_pop         = take && w_head_valid && !redirect;
    assign w_fifo_pop    = w_pop && !w_fifo_empty;
    // A bypassed response that is consumed immediately never enters the queue.
    assign w_push        = w_keep_rsp && !redirect && !(w_bypass && w_pop);

    assign instrValid    = w_head_valid;
    assign instrF        = w_bypass     ? imemRdata :
                           w_fifo_empty ? NOP_INSTR : r_instr_mem[r_rd_ptr];
    // When empty, respPC is the PC of the next instruction to arrive; it also
    // tags a bypassed response.
    assign PCF           = w_fifo_empty ? r_resp_pc : r_pc_mem[r_rd_ptr];
    assign PCPlus4F      = PCF + 32'd4;
    assign imemReq       = w_req;
    assign imemAddr      = r_fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            // No request is issued during a redirect, and every request still
            // outstanding afterwards belongs to a stale stream (earlier drops
            // are already part of r_inflight), so all of them get discarded.
            r_inflight <= r_inflight - OUT_W'(imemRvalid);
            r_drop_cnt <= r_inflight - OUT_W'(imemRvalid);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= r_inflight + OUT_W'(w_grant) - OUT_W'(imemRvalid);
            if (imemRvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - OUT_W'(1);
            end
            if (w_keep_rsp) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imemRdata;
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instruction_prefetch_buffer
//
// Directed bench for instruction_prefetch_buffer. A small in-order memory
// returns ~address as the instruction, with a fixed grant-to-response delay.
// ---------------------------------------------------------------------------
module tb_instruction_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        take;
    logic        instrValid;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;

    int checks = 0;
    int errors = 0;
    int cyc;
    int lat;
    int max_out;
    int grants;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_instr[$];

    instruction_prefetch_buffer #(
        .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirectPC(redirectPC),
        .take(take), .instrValid(instrValid), .instrF(instrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemGnt(imemGnt), .imemRvalid(imemRvalid), .imemRdata(imemRdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Finish the current cycle: record grants/deliveries, then present the
    // memory response for the next cycle.
    task automatic tick();
        @(negedge clk);
        if (imemReq && imemGnt) begin
            q_addr.push_back(imemAddr);
            q_due.push_back(cyc + lat);
            grants++;
        end
        if (q_addr.size() > max_out) max_out = q_addr.size();
        if (instrValid && take && !redirect) begin
            log_pc.push_back(PCF);
            log_instr.push_back(instrF);
        end
        @(posedge clk);
        #1;
        cyc++;
        imemRvalid = 1'b0;
        imemRdata  = 32'h0;
        if (q_addr.size() > 0 && q_due[0] == cyc) begin
            imemRvalid = 1'b1;
            imemRdata  = ~q_addr[0];
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    task automatic drive(input logic t, input logic r, input logic [31:0] pc);
        take       = t;
        redirect   = r;
        redirectPC = pc;
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1; take = 1'b0; redirect = 1'b0; redirectPC = 32'h0;
        imemGnt = 1'b1; imemRvalid = 1'b0; imemRdata = 32'h0;
        q_addr.delete(); q_due.delete(); log_pc.delete(); log_instr.delete();
        max_out = 0; grants = 0; lat = l;
        @(posedge clk);
        #2;
        chk("rst_req", {31'b0, imemReq}, 32'd0);
        chk("rst_valid", {31'b0, instrValid}, 32'd0);
        chk("rst_instr", instrF, 32'h0000_0013);
        chk("rst_pcf", PCF, 32'h0000_0000);
        chk("rst_pc4", PCPlus4F, 32'h0000_0004);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [31:0] e;

        // Zero-wait memory, take held high: gap-free sequential stream.
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk("t1_req", {31'b0, imemReq}, 32'd1);
            chk("t1_addr", imemAddr, 32'(4 * c));
            if (c < FIRST) begin
                chk("t1_novalid", {31'b0, instrValid}, 32'd0);
            end else begin
                e = 32'(4 * (c - FIRST));
                chk("t1_valid", {31'b0, instrValid}, 32'd1);
                chk("t1_pcf", PCF, e);
                chk("t1_instr", instrF, ~e);
                chk("t1_pc4", PCPlus4F, e + 32'd4);
            end
            tick();
        end

        // Stall for 10 cycles: only DEPTH requests, then drain in order.
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (c == 9) begin
                chk("t2_req_off", {31'b0, imemReq}, 32'd0);
                chk("t2_valid", {31'b0, instrValid}, 32'd1);
                chk("t2_head", PCF, 32'h0);
            end
            tick();
        end
        chk("t2_grants", grants, 32'd4);
        for (int c = 10; c < 15; c++) begin
            drive(1'b1, 1'b0, 32'h0);
            e = 32'(4 * (c - 10));
            chk("t2_drain_pc", PCF, e);
            chk("t2_drain_instr", instrF, ~e);
            if (c == 10) chk("t2_req_full", {31'b0, imemReq}, 32'd0);
            if (c == 11) begin
                chk("t2_resume_req", {31'b0, imemReq}, 32'd1);
                chk("t2_resume_addr", imemAddr, 32'h10);
            end
            tick();
        end

        // Response two cycles after grant: outstanding capped at 2,
        // two instructions every three cycles.
        do_reset(2);
        for (int c = 0; c < 15; c++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (c == 3) begin
                log_pc.delete();
                log_instr.delete();
            end
            tick();
        end
        chk("t3_max_out", max_out, 32'd2);
        chk("t3_deliveries", log_pc.size(), 32'd8);
        if (log_pc.size() == 8) begin
            chk("t3_first_pc", log_pc[0], (FIRST == 1) ? 32'h4 : 32'h0);
            chk("t3_last_pc", log_pc[7], log_pc[0] + 32'd28);
            chk("t3_last_instr", log_instr[7], ~(log_pc[0] + 32'd28));
        end

        // Redirect to 0x100 with 0x0/0x4 queued and 0x8/0xC in flight.
        do_reset(2);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (c == 4) chk("t4_addr_c", imemAddr, 32'hC);
            tick();
        end
        drive(1'b0, 1'b1, 32'h100);
        chk("t4_head_before", PCF, 32'h0);
        chk("t4_req_redirect", {31'b0, imemReq}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t4_flushed", {31'b0, instrValid}, 32'd0);
        chk("t4_req_new", {31'b0, imemReq}, 32'd1);
        chk("t4_addr_new", imemAddr, 32'h100);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t4_drop_c", {31'b0, instrValid}, 32'd0);
        chk("t4_addr_next", imemAddr, 32'h104);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t4_valid", {31'b0, instrValid}, 32'd1);
        chk("t4_pcf", PCF, 32'h100);
        chk("t4_instr", instrF, 32'hFFFF_FEFF);
        chk("t4_pc4", PCPlus4F, 32'h104);
        tick();

        // Redirect coinciding with a response and take, then a second
        // redirect while a drop is still pending.
        do_reset(2);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h180);
        log_pc.delete();
        log_instr.delete();
        tick();
        drive(1'b1, 1'b1, 32'h200);
        tick();
        for (int c = 7; c < 13; c++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (c < 9) chk("t5_quiet", {31'b0, instrValid}, 32'd0);
            tick();
        end
        chk("t5_count", {31'b0, log_pc.size() >= 2}, 32'd1);
        if (log_pc.size() >= 2) begin
            chk("t5_pc0", log_pc[0], 32'h200);
            chk("t5_instr0", log_instr[0], 32'hFFFF_FDFF);
            chk("t5_pc1", log_pc[1], 32'h204);
            chk("t5_instr1", log_instr[1], 32'hFFFF_FDFB);
        end

        // Redirect near the top of the address space (low bits masked).
        do_reset(1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("t6_req_redirect", {31'b0, imemReq}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t6_addr0", imemAddr, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t6_addr1", imemAddr, 32'h0000_0000);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t6_pcf", PCF, 32'hFFFF_FFFC);
        chk("t6_instr", instrF, 32'h0000_0003);
        chk("t6_pc4_wrap", PCPlus4F, 32'h0000_0000);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        chk("t6_pop_pcf", PCF, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        chk("t6_next_pcf", PCF, 32'h0000_0000);
        chk("t6_next_instr", instrF, 32'hFFFF_FFFF);
        tick();

        // Reset in the middle of operation returns to the reset stream.
        drive(1'b0, 1'b0, 32'h0);
        do_reset(1);
        drive(1'b0, 1'b0, 32'h0);
        chk("t7_req", {31'b0, imemReq}, 32'd1);
        chk("t7_addr", imemAddr, 32'h0);
        chk("t7_valid", {31'b0, instrValid}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
